// File: rtl/eqcomp4bit_bist.sv
// Built-in self test for a 4-bit equality comparator.
// Sweeps all 256 {A,B} operand pairs. Each pair is held for SETTLE cycles and
// the comparator result is then checked against A==B. The run reports a
// mismatch count, the first failing pair and an overall pass flag.
module eqcomp4bit_bist #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_c,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] first_fail,
  output logic       fail_seen
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Value of the settle counter during the last APPLY cycle of a vector.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q;
  logic [7:0] vec_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [8:0] err_q;
  logic [7:0] ff_q;
  logic       fs_q;

  logic       expected;
  logic       mismatch;

  // Reference result for the operand pair currently applied.
  always_comb begin
    expected = (vec_q[7:4] == vec_q[3:0]);
    mismatch = (dut_c != expected);
  end

  // Test sequencer: run control, vector stepping and result capture.
  // Entering DONE leaves busy high for one cycle; the following cycle
  // publishes done/pass. start is honoured only once busy has dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 8'h00;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 9'd0;
      ff_q    <= 8'h00;
      fs_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (busy_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_q == 9'd0);
          end else if (start) begin
            state_q <= APPLY;
            vec_q   <= 8'h00;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 9'd0;
            ff_q    <= 8'h00;
            fs_q    <= 1'b0;
          end
        end
        APPLY: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= 4'd0;
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_q <= err_q + 9'd1;
            if (!fs_q) begin
              ff_q <= vec_q;
              fs_q <= 1'b1;
            end
          end
          if (vec_q == 8'hFF) begin
            state_q <= DONE;
          end else begin
            vec_q   <= vec_q + 8'd1;
            state_q <= APPLY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_out      = vec_q[7:4];
  assign b_out      = vec_q[3:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_seen  = fs_q;

endmodule

// File: tb/tb_eqcomp4bit_bist.sv
// Scoreboard bench for eqcomp4bit_bist: one instance with SETTLE=2 and a
// selectable comparator model, one with SETTLE=1 and a single injected fault.
module tb_eqcomp4bit_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance 1 (SETTLE=2)
  logic       start1 = 1'b0;
  logic       dut_c1;
  logic [3:0] a1, b1;
  logic       busy1, done1, pass1, fs1;
  logic [8:0] err1;
  logic [7:0] ff1;
  int         mode1 = 0; // 0 golden, 1 tied 0, 2 tied 1, 3 inverted
  int         start_cyc1 = 0;

  assign dut_c1 = (mode1 == 0) ? (a1 == b1) :
                  (mode1 == 1) ? 1'b0 :
                  (mode1 == 2) ? 1'b1 : (a1 != b1);

  eqcomp4bit_bist #(.SETTLE(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_c(dut_c1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1), .fail_seen(fs1)
  );

  // Instance 2 (SETTLE=1), golden except a wrong answer at {A,B}=8'hA5
  logic       start2 = 1'b0;
  logic       dut_c2;
  logic [3:0] a2, b2;
  logic       busy2, done2, pass2, fs2;
  logic [8:0] err2;
  logic [7:0] ff2;
  int         start_cyc2 = 0;

  assign dut_c2 = (a2 == b2) ^ ({a2, b2} == 8'hA5);

  eqcomp4bit_bist #(.SETTLE(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .dut_c(dut_c2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail(ff2), .fail_seen(fs2)
  );

  typedef struct {
    logic [8:0] err;
    logic [7:0] ff;
    logic       fs;
    logic       pass;
    logic [7:0] vec;
    int         lat;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] err, input logic [7:0] ff,
                              input logic fs, input logic pass, input int lat);
    exp_t e;
    e.err = err; e.ff = ff; e.fs = fs; e.pass = pass; e.vec = 8'hFF; e.lat = lat;
    return e;
  endfunction

  // Monitor for instance 1: compare against the oldest expectation when done rises.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done1 && !prev) begin
        if (q1.size() == 0) begin
          chk("dut1 unexpected done", 32'(done1), 32'd0);
        end else begin
          e = q1.pop_front();
          chk("dut1 latency",    32'(cyc - start_cyc1), 32'(e.lat));
          chk("dut1 err_count",  32'(err1), 32'(e.err));
          chk("dut1 first_fail", 32'(ff1), 32'(e.ff));
          chk("dut1 fail_seen",  32'(fs1), 32'(e.fs));
          chk("dut1 pass",       32'(pass1), 32'(e.pass));
          chk("dut1 final vec",  32'({a1, b1}), 32'(e.vec));
          chk("dut1 busy at done", 32'(busy1), 32'd0);
        end
      end
      prev = done1;
    end
  end

  // Monitor for instance 2.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done2 && !prev) begin
        if (q2.size() == 0) begin
          chk("dut2 unexpected done", 32'(done2), 32'd0);
        end else begin
          e = q2.pop_front();
          chk("dut2 latency",    32'(cyc - start_cyc2), 32'(e.lat));
          chk("dut2 err_count",  32'(err2), 32'(e.err));
          chk("dut2 first_fail", 32'(ff2), 32'(e.ff));
          chk("dut2 fail_seen",  32'(fs2), 32'(e.fs));
          chk("dut2 pass",       32'(pass2), 32'(e.pass));
          chk("dut2 final vec",  32'({a2, b2}), 32'(e.vec));
        end
      end
      prev = done2;
    end
  end

  task automatic pulse_start1();
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    start_cyc1 = cyc;
  endtask

  task automatic pulse_start2();
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    start_cyc2 = cyc;
  endtask

  task automatic drain1(input string name);
    int n;
    n = 0;
    while (q1.size() != 0 && n < 1500) begin
      @(posedge clk);
      n++;
    end
    if (q1.size() != 0) begin
      chk({name, " timeout"}, 32'(q1.size()), 32'd0);
      q1.delete();
    end
  endtask

  task automatic drain2(input string name);
    int n;
    n = 0;
    while (q2.size() != 0 && n < 1500) begin
      @(posedge clk);
      n++;
    end
    if (q2.size() != 0) begin
      chk({name, " timeout"}, 32'(q2.size()), 32'd0);
      q2.delete();
    end
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, " a_out"},      32'(a1), 32'd0);
    chk({tag, " b_out"},      32'(b1), 32'd0);
    chk({tag, " busy"},       32'(busy1), 32'd0);
    chk({tag, " done"},       32'(done1), 32'd0);
    chk({tag, " pass"},       32'(pass1), 32'd0);
    chk({tag, " err_count"},  32'(err1), 32'd0);
    chk({tag, " first_fail"}, 32'(ff1), 32'd0);
    chk({tag, " fail_seen"},  32'(fs1), 32'd0);
  endtask

  initial begin
    int n;
    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero1("reset");
    chk("reset dut2 busy", 32'(busy2), 32'd0);
    chk("reset dut2 done", 32'(done2), 32'd0);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle after reset busy", 32'(busy1), 32'd0);
    chk("idle after reset done", 32'(done1), 32'd0);

    // Golden comparator
    mode1 = 0;
    q1.push_back(mk(9'd0, 8'h00, 1'b0, 1'b1, 769));
    pulse_start1();
    drain1("golden");

    // Comparator output stuck at 0
    mode1 = 1;
    q1.push_back(mk(9'd16, 8'h00, 1'b1, 1'b0, 769));
    pulse_start1();
    drain1("tied0");

    // Restart from DONE: counters cleared and busy one edge after start
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done held err_count", 32'(err1), 32'd16);
    chk("done held done", 32'(done1), 32'd1);
    mode1 = 0;
    q1.push_back(mk(9'd0, 8'h00, 1'b0, 1'b1, 769));
    pulse_start1();
    @(negedge clk);
    chk("restart busy", 32'(busy1), 32'd1);
    chk("restart done", 32'(done1), 32'd0);
    chk("restart err_count", 32'(err1), 32'd0);
    chk("restart fail_seen", 32'(fs1), 32'd0);
    chk("restart first_fail", 32'(ff1), 32'd0);
    chk("restart vec", 32'({a1, b1}), 32'd0);
    drain1("restart");

    // Comparator output stuck at 1
    mode1 = 2;
    q1.push_back(mk(9'd240, 8'h01, 1'b1, 1'b0, 769));
    pulse_start1();
    drain1("tied1");

    // Inverted comparator
    mode1 = 3;
    q1.push_back(mk(9'd256, 8'h00, 1'b1, 1'b0, 769));
    pulse_start1();
    drain1("inverted");

    // start while busy is ignored: latency still measured from the first start
    mode1 = 0;
    q1.push_back(mk(9'd0, 8'h00, 1'b0, 1'b1, 769));
    pulse_start1();
    repeat (100) @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (300) @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    drain1("start while busy");

    // Reset in the middle of a run at vector 8'h40
    mode1 = 0;
    pulse_start1();
    n = 0;
    @(negedge clk);
    while (!(a1 == 4'h4 && b1 == 4'h0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach vec 40", 32'({a1, b1}), 32'h40);
    rst = 1'b1;
    @(negedge clk);
    chk_zero1("midrun reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post reset idle busy", 32'(busy1), 32'd0);
    chk("post reset idle vec", 32'({a1, b1}), 32'd0);
    q1.push_back(mk(9'd0, 8'h00, 1'b0, 1'b1, 769));
    pulse_start1();
    drain1("after reset");

    // SETTLE=1 with a single injected fault
    q2.push_back(mk(9'd1, 8'hA5, 1'b1, 1'b0, 513));
    pulse_start2();
    drain2("settle1 inject");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
